// File: rtl/item_spawn_ctrl_if.sv
// Generator handshake bundle between item_spawn_ctrl (master) and the item-position generator (slave).
// o_Gen_Req stays high while the controller wants a position; the generator answers with a
// one-cycle i_Gen_Done carrying i_Gen_x/i_Gen_y, and the controller only consumes it while waiting.
interface item_spawn_ctrl_if;
   logic       o_Gen_Req;
   logic       i_Gen_Done;
   logic [5:0] i_Gen_x;
   logic [5:0] i_Gen_y;

   modport master (
      output o_Gen_Req,
      input  i_Gen_Done,
      input  i_Gen_x,
      input  i_Gen_y
   );

   modport slave (
      input  o_Gen_Req,
      output i_Gen_Done,
      output i_Gen_x,
      output i_Gen_y
   );
endinterface

// File: rtl/item_spawn_ctrl.sv
// Snake item sequencer: requests a food position, latches it, detects eats and keeps the score.
// Optional macro ITEM_LIFETIME_EN: items expire after ITEM_LIFE ticks without being eaten.
module item_spawn_ctrl #(
   parameter int         SCORE_W     = 10,
   parameter int         GEN_TIMEOUT = 256,
   parameter logic [5:0] DEF_X       = 6'd5,
   parameter logic [5:0] DEF_Y       = 6'd5,
   parameter int         ITEM_LIFE   = 64
) (
   input  logic               i_Clk,
   input  logic               i_Rst,
   input  logic               i_Game_start,
   input  logic               i_Game_over,
   input  logic               i_Tick,
   input  logic [5:0]         i_Head_x,
   input  logic [5:0]         i_Head_y,
   item_spawn_ctrl_if.master  gen,
   output logic [5:0]         o_Item_x,
   output logic [5:0]         o_Item_y,
   output logic               o_Item_valid,
   output logic               o_Grow,
   output logic [SCORE_W-1:0] o_Score,
   output logic               o_Gen_Err,
   output logic [1:0]         o_Dbg_State
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REQ    = 2'd1,
      S_WAIT   = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   localparam int                WAIT_W    = $clog2(GEN_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(GEN_TIMEOUT - 1);

   if (GEN_TIMEOUT < 2 || ITEM_LIFE < 1) begin : g_bad_param
      $error("item_spawn_ctrl: GEN_TIMEOUT must be >= 2 and ITEM_LIFE >= 1");
   end

   state_t              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [5:0]          item_x_q, item_x_d;
   logic [5:0]          item_y_q, item_y_d;
   logic                valid_q, valid_d;
   logic                grow_q, grow_d;
   logic [SCORE_W-1:0]  score_q, score_d;
   logic                err_q, err_d;
   logic                head_hit;

`ifdef ITEM_LIFETIME_EN
   localparam int                LIFE_W    = (ITEM_LIFE > 1) ? $clog2(ITEM_LIFE) : 1;
   localparam logic [LIFE_W-1:0] LIFE_LAST = LIFE_W'(ITEM_LIFE - 1);
   logic [LIFE_W-1:0]   life_q, life_d;
`endif

   assign head_hit = (i_Head_x == item_x_q) && (i_Head_y == item_y_q);

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      item_x_d = item_x_q;
      item_y_d = item_y_q;
      valid_d  = valid_q;
      grow_d   = 1'b0;
      score_d  = score_q;
      err_d    = err_q;
`ifdef ITEM_LIFETIME_EN
      life_d   = life_q;
`endif
      // Game over outranks game start so a simultaneous pair leaves the game stopped.
      if (i_Game_over) begin
         state_d = S_IDLE;
         valid_d = 1'b0;
      end else if (i_Game_start) begin
         state_d = S_REQ;
         valid_d = 1'b0;
         score_d = '0;
         err_d   = 1'b0;
         wait_d  = '0;
`ifdef ITEM_LIFETIME_EN
         life_d  = '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_REQ: begin
               wait_d  = '0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               // A real result arriving on the timeout cycle still beats the fallback.
               if (gen.i_Gen_Done) begin
                  item_x_d = gen.i_Gen_x;
                  item_y_d = gen.i_Gen_y;
                  valid_d  = 1'b1;
                  state_d  = S_ACTIVE;
`ifdef ITEM_LIFETIME_EN
                  life_d   = '0;
`endif
               end else if (wait_q == WAIT_LAST) begin
                  item_x_d = DEF_X;
                  item_y_d = DEF_Y;
                  err_d    = 1'b1;
                  valid_d  = 1'b1;
                  state_d  = S_ACTIVE;
`ifdef ITEM_LIFETIME_EN
                  life_d   = '0;
`endif
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
            S_ACTIVE: begin
               if (i_Tick) begin
                  if (head_hit) begin
                     grow_d  = 1'b1;
                     score_d = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + 1'b1;
                     valid_d = 1'b0;
                     state_d = S_REQ;
`ifdef ITEM_LIFETIME_EN
                  end else if (life_q == LIFE_LAST) begin
                     valid_d = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     life_d = life_q + 1'b1;
`endif
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state_q  <= S_IDLE;
         wait_q   <= '0;
         item_x_q <= '0;
         item_y_q <= '0;
         valid_q  <= 1'b0;
         grow_q   <= 1'b0;
         score_q  <= '0;
         err_q    <= 1'b0;
`ifdef ITEM_LIFETIME_EN
         life_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wait_q   <= wait_d;
         item_x_q <= item_x_d;
         item_y_q <= item_y_d;
         valid_q  <= valid_d;
         grow_q   <= grow_d;
         score_q  <= score_d;
         err_q    <= err_d;
`ifdef ITEM_LIFETIME_EN
         life_q   <= life_d;
`endif
      end
   end

   assign gen.o_Gen_Req = (state_q == S_REQ) || (state_q == S_WAIT);
   assign o_Item_x      = item_x_q;
   assign o_Item_y      = item_y_q;
   assign o_Item_valid  = valid_q;
   assign o_Grow        = grow_q;
   assign o_Score       = score_q;
   assign o_Gen_Err     = err_q;
   assign o_Dbg_State   = state_q;

endmodule

// File: tb/tb_item_spawn_ctrl.sv
// Bench for item_spawn_ctrl: directed vector table, hand sequences for corner cases,
// and random stimulus against a phase/age reference model.
module tb_item_spawn_ctrl;
   localparam int SW        = 2;
   localparam int GT        = 8;
   localparam int IL        = 3;
   localparam int SCORE_MAX = (1 << SW) - 1;

   logic          clk;
   logic          rst_n;
   logic          st, ov, tk;
   logic [5:0]    hx, hy;
   logic [5:0]    item_x, item_y;
   logic          item_valid, grow, gen_err;
   logic [SW-1:0] score;
   logic [1:0]    dbg_state;

   item_spawn_ctrl_if gen_if ();

   item_spawn_ctrl #(
      .SCORE_W     (SW),
      .GEN_TIMEOUT (GT),
      .ITEM_LIFE   (IL)
   ) dut (
      .i_Clk        (clk),
      .i_Rst        (rst_n),
      .i_Game_start (st),
      .i_Game_over  (ov),
      .i_Tick       (tk),
      .i_Head_x     (hx),
      .i_Head_y     (hy),
      .gen          (gen_if),
      .o_Item_x     (item_x),
      .o_Item_y     (item_y),
      .o_Item_valid (item_valid),
      .o_Grow       (grow),
      .o_Score      (score),
      .o_Gen_Err    (gen_err),
      .o_Dbg_State  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model: phase 0 idle, 1 requesting (age 0 = request cycle, age k = k-th wait cycle), 2 live.
   int         m_phase, m_age, m_life, m_score;
   logic       m_err, m_grow;
   logic [5:0] m_x, m_y;

   typedef struct {
      logic       st, ov, tk, dn;
      logic [5:0] hx, hy, gx, gy;
      logic       e_req, e_val, e_grow;
      int         e_score;
      logic       e_err;
      logic [5:0] e_x, e_y;
   } vec_t;

   function automatic vec_t mk(logic a_st, logic a_ov, logic a_tk, logic a_dn,
                               logic [5:0] a_hx, logic [5:0] a_hy, logic [5:0] a_gx, logic [5:0] a_gy,
                               logic a_rq, logic a_vl, logic a_gr, int a_sc, logic a_er,
                               logic [5:0] a_x, logic [5:0] a_y);
      vec_t v;
      v.st = a_st; v.ov = a_ov; v.tk = a_tk; v.dn = a_dn;
      v.hx = a_hx; v.hy = a_hy; v.gx = a_gx; v.gy = a_gy;
      v.e_req = a_rq; v.e_val = a_vl; v.e_grow = a_gr; v.e_score = a_sc; v.e_err = a_er;
      v.e_x = a_x; v.e_y = a_y;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0; m_age = 0; m_life = 0; m_score = 0;
      m_err = 1'b0; m_grow = 1'b0; m_x = '0; m_y = '0;
   endtask

   task automatic model_step();
      logic g;
      g = 1'b0;
      if (ov) m_phase = 0;
      else if (st) begin
         m_phase = 1; m_age = 0; m_score = 0; m_err = 1'b0;
      end else if (m_phase == 1) begin
         if (m_age >= 1 && gen_if.i_Gen_Done) begin
            m_x = gen_if.i_Gen_x; m_y = gen_if.i_Gen_y; m_phase = 2; m_life = 0;
         end else if (m_age == GT) begin
            m_x = 6'd5; m_y = 6'd5; m_err = 1'b1; m_phase = 2; m_life = 0;
         end else m_age++;
      end else if (m_phase == 2 && tk) begin
         m_life++;
         if (hx == m_x && hy == m_y) begin
            g = 1'b1;
            if (m_score < SCORE_MAX) m_score++;
            m_phase = 1; m_age = 0;
         end
`ifdef ITEM_LIFETIME_EN
         else if (m_life == IL) begin
            m_phase = 1; m_age = 0;
         end
`endif
      end
      m_grow = g;
   endtask

   task automatic drive(input logic a_st, input logic a_ov, input logic a_tk, input logic a_dn,
                        input logic [5:0] a_hx, input logic [5:0] a_hy,
                        input logic [5:0] a_gx, input logic [5:0] a_gy);
      st = a_st; ov = a_ov; tk = a_tk; hx = a_hx; hy = a_hy;
      gen_if.i_Gen_Done = a_dn; gen_if.i_Gen_x = a_gx; gen_if.i_Gen_y = a_gy;
   endtask

   task automatic step_clk();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_req"},   int'(gen_if.o_Gen_Req), int'(m_phase == 1));
      chk({tag, "_valid"}, int'(item_valid),       int'(m_phase == 2));
      chk({tag, "_grow"},  int'(grow),             int'(m_grow));
      chk({tag, "_score"}, int'(score),            m_score);
      chk({tag, "_err"},   int'(gen_err),          int'(m_err));
      chk({tag, "_x"},     int'(item_x),           int'(m_x));
      chk({tag, "_y"},     int'(item_y),           int'(m_y));
   endtask

   task automatic cyc(input string tag, input logic a_st, input logic a_ov, input logic a_tk,
                      input logic a_dn, input logic [5:0] a_hx, input logic [5:0] a_hy,
                      input logic [5:0] a_gx, input logic [5:0] a_gy);
      drive(a_st, a_ov, a_tk, a_dn, a_hx, a_hy, a_gx, a_gy);
      step_clk();
      check_model(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 6'd63, 6'd63, 6'd0, 6'd0);
   endtask

   vec_t tbl[16];

   initial begin
      tbl[0]  = mk(1,0,0,0, 0,0, 0,0,     1,0,0,0,0,  0,0);
      tbl[1]  = mk(0,0,0,0, 0,0, 0,0,     1,0,0,0,0,  0,0);
      tbl[2]  = mk(0,0,0,0, 0,0, 0,0,     1,0,0,0,0,  0,0);
      tbl[3]  = mk(0,0,0,0, 0,0, 0,0,     1,0,0,0,0,  0,0);
      tbl[4]  = mk(0,0,0,0, 0,0, 0,0,     1,0,0,0,0,  0,0);
      tbl[5]  = mk(0,0,0,1, 0,0, 12,30,   0,1,0,0,0,  12,30);
      tbl[6]  = mk(0,0,0,0, 12,30, 0,0,   0,1,0,0,0,  12,30);
      tbl[7]  = mk(0,0,1,0, 12,30, 0,0,   1,0,1,1,0,  12,30);
      tbl[8]  = mk(0,0,0,0, 0,0, 0,0,     1,0,0,1,0,  12,30);
      tbl[9]  = mk(0,0,1,0, 12,30, 0,0,   1,0,0,1,0,  12,30);
      tbl[10] = mk(0,0,0,1, 0,0, 3,4,     0,1,0,1,0,  3,4);
      tbl[11] = mk(0,0,1,0, 12,30, 0,0,   0,1,0,1,0,  3,4);
      tbl[12] = mk(0,0,1,0, 3,5, 0,0,     0,1,0,1,0,  3,4);
      tbl[13] = mk(0,0,1,0, 3,4, 0,0,     1,0,1,2,0,  3,4);
      tbl[14] = mk(0,1,0,0, 0,0, 0,0,     0,0,0,2,0,  3,4);
      tbl[15] = mk(0,0,0,1, 0,0, 9,9,     0,0,0,2,0,  3,4);

      // Reset held low for three cycles.
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model("in_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_model("post_reset");
      chk("post_reset_state", int'(dbg_state), 0);

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].st, tbl[i].ov, tbl[i].tk, tbl[i].dn, tbl[i].hx, tbl[i].hy, tbl[i].gx, tbl[i].gy);
         step_clk();
         chk($sformatf("tbl%0d_req", i),   int'(gen_if.o_Gen_Req), int'(tbl[i].e_req));
         chk($sformatf("tbl%0d_valid", i), int'(item_valid),       int'(tbl[i].e_val));
         chk($sformatf("tbl%0d_grow", i),  int'(grow),             int'(tbl[i].e_grow));
         chk($sformatf("tbl%0d_score", i), int'(score),            tbl[i].e_score);
         chk($sformatf("tbl%0d_err", i),   int'(gen_err),          int'(tbl[i].e_err));
         chk($sformatf("tbl%0d_x", i),     int'(item_x),           int'(tbl[i].e_x));
         chk($sformatf("tbl%0d_y", i),     int'(item_y),           int'(tbl[i].e_y));
      end

      // Generator never answers: fallback after the eighth wait cycle.
      cyc("to_start", 1, 0, 0, 0, 63, 63, 0, 0);
      idle("to_wait", 8);
      chk("to_still_req", int'(gen_if.o_Gen_Req), 1);
      idle("to_fire", 1);
      chk("to_x", int'(item_x), 5);
      chk("to_y", int'(item_y), 5);
      chk("to_valid", int'(item_valid), 1);
      chk("to_err", int'(gen_err), 1);

      // Done on the final wait cycle wins over the timeout; restart clears the error.
      cyc("dl_start", 1, 0, 0, 0, 63, 63, 0, 0);
      chk("dl_err_clr", int'(gen_err), 0);
      idle("dl_wait", 8);
      cyc("dl_done", 0, 0, 0, 1, 63, 63, 20, 21);
      chk("dl_x", int'(item_x), 20);
      chk("dl_err", int'(gen_err), 0);

      // Four eats with a 2-bit score saturate at 3.
      cyc("sat_start", 1, 0, 0, 0, 63, 63, 0, 0);
      for (int i = 0; i < 4; i++) begin
         idle("sat_req", 1);
         cyc("sat_done", 0, 0, 0, 1, 63, 63, 6'(i + 1), 6'(i + 2));
         cyc("sat_eat", 0, 0, 1, 0, 6'(i + 1), 6'(i + 2), 0, 0);
         chk("sat_grow", int'(grow), 1);
         chk("sat_score", int'(score), (i + 1 > 3) ? 3 : i + 1);
      end

      // Game over while waiting keeps the score.
      idle("ovw_wait", 2);
      cyc("ovw_over", 0, 1, 0, 0, 63, 63, 0, 0);
      chk("ovw_req", int'(gen_if.o_Gen_Req), 0);
      chk("ovw_score", int'(score), 3);

      // Game over while active, then simultaneous over+start.
      cyc("ova_start", 1, 0, 0, 0, 63, 63, 0, 0);
      idle("ova_req", 1);
      cyc("ova_done", 0, 0, 0, 1, 63, 63, 10, 11);
      cyc("ova_eat", 0, 0, 1, 0, 10, 11, 0, 0);
      idle("ova_req2", 1);
      cyc("ova_done2", 0, 0, 0, 1, 63, 63, 40, 41);
      cyc("ova_over", 0, 1, 0, 0, 63, 63, 0, 0);
      chk("ova_valid", int'(item_valid), 0);
      chk("ova_score", int'(score), 1);
      cyc("both", 1, 1, 0, 0, 63, 63, 0, 0);
      chk("both_req", int'(gen_if.o_Gen_Req), 0);
      chk("both_score", int'(score), 1);

`ifdef ITEM_LIFETIME_EN
      // Item expires after three ticks without an eat; eat on the third tick still counts.
      cyc("life_start", 1, 0, 0, 0, 63, 63, 0, 0);
      idle("life_req", 1);
      cyc("life_done", 0, 0, 0, 1, 63, 63, 8, 9);
      cyc("life_t1", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("life_t2", 0, 0, 1, 0, 0, 0, 0, 0);
      chk("life_alive", int'(item_valid), 1);
      cyc("life_t3", 0, 0, 1, 0, 0, 0, 0, 0);
      chk("life_expired", int'(item_valid), 0);
      chk("life_rereq", int'(gen_if.o_Gen_Req), 1);
      chk("life_score", int'(score), 0);
      idle("life_req2", 1);
      cyc("life_done2", 0, 0, 0, 1, 63, 63, 8, 9);
      cyc("life_u1", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("life_u2", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("life_u3", 0, 0, 1, 0, 8, 9, 0, 0);
      chk("life_eat_grow", int'(grow), 1);
      chk("life_eat_score", int'(score), 1);
`endif

      // Randomized run against the model.
      for (int i = 0; i < 2000; i++) begin
         logic [5:0] rhx, rhy;
         if ($urandom_range(0, 1) == 1) begin
            rhx = m_x; rhy = m_y;
         end else begin
            rhx = 6'($urandom_range(0, 7)); rhy = 6'($urandom_range(0, 7));
         end
         cyc("rnd", $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
             rhx, rhy, 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      end

      // Asynchronous reset in the middle of an eat: outputs clear at once, no grow follows.
      cyc("ar_start", 1, 0, 0, 0, 63, 63, 0, 0);
      idle("ar_req", 1);
      cyc("ar_done", 0, 0, 0, 1, 63, 63, 7, 7);
      drive(0, 0, 1, 0, 7, 7, 0, 0);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_model("ar_now");
      @(posedge clk); #1;
      check_model("ar_edge");
      chk("ar_state", int'(dbg_state), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle("ar_after", 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
